// File: rtl/uart_serial_bridge_if.sv
// CPU-side parallel handshake and serial pins of the UART serial bridge.
// The master modport is the CPU/line side; the slave modport is the bridge.
interface uart_serial_bridge_if;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       WR;
    logic       _RD;
    logic       _TXE;
    logic       _RXF;
    logic       tx;
    logic       rx;
    logic       tx_overflow;
    logic       rx_overflow;
    logic       frame_err;

    modport master (
        output D_in, WR, _RD, rx,
        input  D_out, D_oe, _TXE, _RXF, tx, tx_overflow, rx_overflow, frame_err
    );

    modport slave (
        input  D_in, WR, _RD, rx,
        output D_out, D_oe, _TXE, _RXF, tx, tx_overflow, rx_overflow, frame_err
    );
endinterface

// File: rtl/uart_serial_bridge.sv
// UART serial bridge: UM245R-style WR/_RD/_TXE/_RXF handshake on the CPU side,
// TX/RX FIFOs and 8N1 shifters on the serial side.
module uart_serial_bridge #(
    parameter int DIVISOR = 16,
    parameter int FIFO_AW = 2,
    parameter int LOG     = 0
) (
    input  logic                clk,
    input  logic                _MR,
    uart_serial_bridge_if.slave bus
);
    localparam int          DEPTH   = 2 ** FIFO_AW;
    localparam logic [15:0] DIV_M1  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    typedef logic [FIFO_AW:0] ptr_t;

    function automatic logic is_full(input ptr_t w, input ptr_t r);
        return (w ^ r) == ptr_t'(DEPTH);
    endfunction

    // LOG only selects tracing in the behavioural model; hardware has no trace path.
    if (LOG != 0) begin : g_trace_unused
    end

    // Synchronizers preset to the idle-high level so reset release makes no edge.
    logic [1:0] wr_sync_q, rd_sync_q, rx_sync_q;
    logic       wr_prev_q, rd_prev_q, rx_prev_q;
    logic       rx_s, wr_fall, rd_rise, rx_fall;

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            wr_sync_q <= 2'b11;
            rd_sync_q <= 2'b11;
            rx_sync_q <= 2'b11;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_sync_q <= {wr_sync_q[0], bus.WR};
            rd_sync_q <= {rd_sync_q[0], bus._RD};
            rx_sync_q <= {rx_sync_q[0], bus.rx};
            wr_prev_q <= wr_sync_q[1];
            rd_prev_q <= rd_sync_q[1];
            rx_prev_q <= rx_sync_q[1];
        end
    end

    assign rx_s    = rx_sync_q[1];
    assign wr_fall = wr_prev_q & ~wr_sync_q[1];
    assign rd_rise = ~rd_prev_q & rd_sync_q[1];
    assign rx_fall = rx_prev_q & ~rx_s;

    // ---------------- TX FIFO ----------------
    logic [7:0] tx_mem_q [DEPTH];
    ptr_t       tx_wptr_q, tx_rptr_q, tx_wptr_d, tx_rptr_d;
    logic       tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty  = (tx_wptr_q == tx_rptr_q);
    assign tx_full   = is_full(tx_wptr_q, tx_rptr_q);
    assign tx_push   = wr_fall & (~tx_full | tx_pop);
    assign tx_wptr_d = tx_push ? tx_wptr_q + ptr_t'(1) : tx_wptr_q;
    assign tx_rptr_d = tx_pop  ? tx_rptr_q + ptr_t'(1) : tx_rptr_q;

    // NOTE: storage arrays carry no reset; the reset pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[FIFO_AW-1:0]] <= bus.D_in;
    end

    // ---------------- TX FSM ----------------
    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d;

    // A new byte loads from IDLE or straight out of the stop bit, so frames abut.
    assign tx_pop = ~tx_empty & ((tx_state_q == S_IDLE) |
                                 ((tx_state_q == S_STOP) & (tx_cnt_q == 16'd0)));

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        case (tx_state_q)
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_d       = tx_sh_q[0];
                    tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = S_DATA;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = DIV_M1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            S_STOP: begin
                if (tx_cnt_q == 16'd0) tx_state_d = S_IDLE;
                else                   tx_cnt_d   = tx_cnt_q - 16'd1;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_sh_d    = tx_mem_q[tx_rptr_q[FIFO_AW-1:0]];
            tx_d       = 1'b0;
            tx_cnt_d   = DIV_M1;
            tx_state_d = S_START;
        end
    end

    // ---------------- RX FSM ----------------
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_stop_smp;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_stop_smp = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = HALF_M1;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s) rx_state_d = S_IDLE;
                    else begin
                        rx_cnt_d   = DIV_M1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = S_DATA;
                    end
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    rx_cnt_d = DIV_M1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_stop_smp = 1'b1;
                    rx_state_d  = S_IDLE;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0] rx_mem_q [DEPTH];
    ptr_t       rx_wptr_q, rx_rptr_q, rx_wptr_d, rx_rptr_d;
    logic       rx_empty, rx_full, rx_push_req, rx_push, rx_pop;
    logic [7:0] rx_head, dout_q, dout_d;

    assign rx_empty    = (rx_wptr_q == rx_rptr_q);
    assign rx_full     = is_full(rx_wptr_q, rx_rptr_q);
    assign rx_pop      = rd_rise & ~rx_empty;
    assign rx_push_req = rx_stop_smp & rx_s;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_wptr_d   = rx_push ? rx_wptr_q + ptr_t'(1) : rx_wptr_q;
    assign rx_rptr_d   = rx_pop  ? rx_rptr_q + ptr_t'(1) : rx_rptr_q;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q[FIFO_AW-1:0]] <= rx_sh_q;
    end

    // Next head bypasses the array when the byte being pushed becomes the head.
    assign rx_head = (rx_push && (rx_wptr_q == rx_rptr_d)) ? rx_sh_q
                                                           : rx_mem_q[rx_rptr_d[FIFO_AW-1:0]];
    assign dout_d  = (rx_wptr_d == rx_rptr_d) ? dout_q : rx_head;

    // ---------------- state registers ----------------
    logic txe_q, rxf_q, tx_ovf_q, rx_ovf_q, ferr_q;

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            dout_q     <= 8'h00;
            txe_q      <= 1'b0;
            rxf_q      <= 1'b1;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            dout_q     <= dout_d;
            txe_q      <= is_full(tx_wptr_d, tx_rptr_d);
            rxf_q      <= (rx_wptr_d == rx_rptr_d);
            if (wr_fall && !tx_push)          tx_ovf_q <= 1'b1;
            if (rx_push_req && !rx_push)      rx_ovf_q <= 1'b1;
            if (rx_stop_smp && !rx_s)         ferr_q   <= 1'b1;
        end
    end

    assign bus.D_out       = dout_q;
    assign bus.D_oe        = ~bus._RD;
    assign bus._TXE        = txe_q;
    assign bus._RXF        = rxf_q;
    assign bus.tx          = tx_q;
    assign bus.tx_overflow = tx_ovf_q;
    assign bus.rx_overflow = rx_ovf_q;
    assign bus.frame_err   = ferr_q;
endmodule

// File: tb/tb_uart_serial_bridge.sv
// Directed bench for uart_serial_bridge: CPU writes/reads, 8N1 line stimulus,
// a tx frame decoder, and reset-abort behaviour.
module tb_uart_serial_bridge;
    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic clk = 1'b0;
    logic _MR;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [7:0] mon_bytes[$];
    logic       mon_stop[$];
    int         mon_start[$];

    uart_serial_bridge_if bus();

    uart_serial_bridge #(.DIVISOR(DIV), .FIFO_AW(2), .LOG(0)) dut (
        .clk (clk),
        ._MR (_MR),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decodes tx frames by sampling each bit at its centre on the falling clock edge.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       st;
        int         t0;
        forever begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                t0 = cyc;
                repeat (DIV / 2) @(negedge clk);
                st = bus.tx;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clk);
                    b[k] = bus.tx;
                end
                repeat (DIV) @(negedge clk);
                if (st === 1'b0) begin
                    mon_bytes.push_back(b);
                    mon_stop.push_back(bus.tx);
                    mon_start.push_back(t0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_bytes.delete();
        mon_stop.delete();
        mon_start.delete();
    endtask

    task automatic cpu_write(input logic [7:0] b);
        bus.D_in = b;
        bus.WR   = 1'b0;
        tick(4);
        bus.WR   = 1'b1;
        tick(3);
    endtask

    task automatic cpu_read(output logic [7:0] d, output logic oe);
        bus._RD = 1'b0;
        tick(3);
        d  = bus.D_out;
        oe = bus.D_oe;
        tick(1);
        bus._RD = 1'b1;
        tick(4);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        tick(DIV);
        for (int k = 0; k < 8; k++) begin
            bus.rx = b[k];
            tick(DIV);
        end
        bus.rx = stop;
        tick(DIV);
        bus.rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (mon_bytes.size() >= n) ok = 1'b1;
            else tick(1);
        end
    endtask

    // Starts a write and returns the edge (1..4) on which tx fell, or -1.
    task automatic write_and_find_start(input logic [7:0] b, output int fall_at);
        fall_at = -1;
        bus.D_in = b;
        bus.WR   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (fall_at < 0 && bus.tx === 1'b0) fall_at = i;
        end
        bus.WR = 1'b1;
        total++;
        if (fall_at < 0) begin
            bad++;
            $display("FAIL tx_start_latency: tx=%b after 4 clk, required 0", bus.tx);
        end
    endtask

    task automatic test_reset();
        _MR = 1'b0;
        bus.WR = 1'b1; bus._RD = 1'b1; bus.rx = 1'b1; bus.D_in = 8'h00;
        tick(3);
        total++; if (bus.tx !== 1'b1)   begin bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        total++; if (bus._TXE !== 1'b0) begin bad++; $display("FAIL reset_txe: got %b want 0", bus._TXE); end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL reset_rxf: got %b want 1", bus._RXF); end
        total++; if (bus.D_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus.D_out); end
        total++; if (bus.D_oe !== 1'b0) begin bad++; $display("FAIL reset_doe: got %b want 0", bus.D_oe); end
        total++; if ({bus.tx_overflow, bus.rx_overflow, bus.frame_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {bus.tx_overflow, bus.rx_overflow, bus.frame_err});
        end
        _MR = 1'b1;
        tick(3 * DIV);
        total++; if ({bus.tx, bus._TXE, bus._RXF} !== 3'b101) begin
            bad++; $display("FAIL release_idle: got %b want 101", {bus.tx, bus._TXE, bus._RXF});
        end
    endtask

    task automatic test_tx_single();
        int         fall_at;
        logic       ok;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        mon_clear();
        write_and_find_start(8'hA5, fall_at);
        if (fall_at > 0) begin
            tick(fall_at + DIV / 2 - 4);
            for (int k = 0; k < 10; k++) begin
                total++;
                if (bus.tx !== frame[k]) begin
                    bad++; $display("FAIL tx_bit%0d: got %b want %b", k, bus.tx, frame[k]);
                end
                tick(DIV);
            end
        end
        total++; if (bus._TXE !== 1'b0) begin bad++; $display("FAIL tx_single_txe: got %b want 0", bus._TXE); end
        wait_frames(1, 2 * FRAME, ok);
        total++;
        if (!ok || mon_bytes[0] !== 8'hA5) begin
            bad++; $display("FAIL tx_single_frame: seen=%0d byte=%h want A5", ok, ok ? mon_bytes[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        mon_clear();
        for (int i = 1; i <= 5; i++) cpu_write(8'(i));
        total++; if (bus._TXE !== 1'b1) begin bad++; $display("FAIL b2b_txe_full: got %b want 1", bus._TXE); end
        total++; if (bus.tx_overflow !== 1'b0) begin bad++; $display("FAIL b2b_no_ovf: got %b want 0", bus.tx_overflow); end
        cpu_write(8'h66);
        total++; if (bus.tx_overflow !== 1'b1) begin bad++; $display("FAIL b2b_ovf: got %b want 1", bus.tx_overflow); end
        wait_frames(5, 6 * FRAME, ok);
        tick(2 * FRAME);
        total++; if (mon_bytes.size() != 5) begin bad++; $display("FAIL b2b_count: got %0d frames want 5", mon_bytes.size()); end
        for (int i = 0; i < mon_bytes.size() && i < 5; i++) begin
            total++;
            if (mon_bytes[i] !== 8'(i + 1) || mon_stop[i] !== 1'b1) begin
                bad++; $display("FAIL b2b_byte%0d: got %h stop %b want %h stop 1", i, mon_bytes[i], mon_stop[i], 8'(i + 1));
            end
            if (i > 0) begin
                total++;
                if (mon_start[i] - mon_start[i-1] != FRAME) begin
                    bad++; $display("FAIL b2b_gap%0d: got %0d clk want %0d", i, mon_start[i] - mon_start[i-1], FRAME);
                end
            end
        end
        total++; if (bus._TXE !== 1'b0) begin bad++; $display("FAIL b2b_txe_drained: got %b want 0", bus._TXE); end
    endtask

    task automatic test_rx_frame();
        logic [7:0] d;
        logic       oe;
        send_rx(8'h3C, 1'b1);
        tick(2);
        total++; if (bus._RXF !== 1'b0) begin bad++; $display("FAIL rx_rxf_low: got %b want 0", bus._RXF); end
        cpu_read(d, oe);
        total++; if (oe !== 1'b1) begin bad++; $display("FAIL rx_doe: got %b want 1", oe); end
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL rx_dout: got %h want 3C", d); end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL rx_rxf_high: got %b want 1", bus._RXF); end
        total++; if (bus.D_oe !== 1'b0) begin bad++; $display("FAIL rx_doe_release: got %b want 0", bus.D_oe); end
    endtask

    task automatic test_rx_errors();
        bus.rx = 1'b0;
        tick(5);
        bus.rx = 1'b1;
        tick(3 * DIV);
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL false_start_rxf: got %b want 1", bus._RXF); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL false_start_ferr: got %b want 0", bus.frame_err); end
        send_rx(8'h7E, 1'b0);
        tick(DIV);
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL frame_err: got %b want 1", bus.frame_err); end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL frame_err_nopush: got %b want 1", bus._RXF); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] d;
        logic       oe;
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_rx(exp_b[i], 1'b1);
        tick(2);
        total++; if (bus.rx_overflow !== 1'b1) begin bad++; $display("FAIL rx_ovf: got %b want 1", bus.rx_overflow); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(d, oe);
            total++; if (d !== exp_b[i]) begin bad++; $display("FAIL rx_ovf_read%0d: got %h want %h", i, d, exp_b[i]); end
        end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL rx_ovf_empty: got %b want 1", bus._RXF); end
        cpu_read(d, oe);
        total++; if (d !== 8'h44) begin bad++; $display("FAIL read_empty_dout: got %h want 44", d); end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL read_empty_rxf: got %b want 1", bus._RXF); end
        send_rx(8'h99, 1'b1);
        tick(2);
        cpu_read(d, oe);
        total++; if (d !== 8'h99) begin bad++; $display("FAIL after_empty_read: got %h want 99", d); end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL after_empty_rxf: got %b want 1", bus._RXF); end
    endtask

    task automatic test_mr_midframe();
        int   fall_at;
        logic ok;
        send_rx(8'h5A, 1'b1);
        tick(2);
        total++; if (bus._RXF !== 1'b0) begin bad++; $display("FAIL mr_pre_rxf: got %b want 0", bus._RXF); end
        write_and_find_start(8'hC3, fall_at);
        if (fall_at > 0) begin
            tick(fall_at + 4 * DIV + DIV / 2 - 4);
            total++; if (bus.tx !== 1'b0) begin bad++; $display("FAIL mr_pre_bit3: got %b want 0", bus.tx); end
        end
        _MR = 1'b0;
        #1;
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL mr_tx: got %b want 1", bus.tx); end
        total++; if ({bus._TXE, bus._RXF, bus.D_out} !== {1'b0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL mr_handshake: got txe=%b rxf=%b dout=%h want 0 1 00", bus._TXE, bus._RXF, bus.D_out);
        end
        total++; if ({bus.tx_overflow, bus.rx_overflow, bus.frame_err} !== 3'b000) begin
            bad++; $display("FAIL mr_flags: got %b want 000", {bus.tx_overflow, bus.rx_overflow, bus.frame_err});
        end
        tick(3);
        _MR = 1'b1;
        tick(FRAME + 50);
        mon_clear();
        cpu_write(8'h96);
        wait_frames(1, 2 * FRAME, ok);
        total++;
        if (!ok || mon_bytes[0] !== 8'h96 || mon_stop[0] !== 1'b1) begin
            bad++; $display("FAIL mr_new_frame: seen=%0d byte=%h want 96", ok, ok ? mon_bytes[0] : 8'hxx);
        end
        total++; if (bus._RXF !== 1'b1) begin bad++; $display("FAIL mr_rxf_after: got %b want 1", bus._RXF); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_frame();
        test_rx_errors();
        test_rx_overflow();
        test_mr_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
